// File: rtl/shift_arbiter_if.sv
// Two-requester shift bus with a single result channel.
// Both sides use valid/ready handshakes.
interface shift_arbiter_if;
  logic       req0_valid;
  logic [3:0] req0_a;
  logic [1:0] req0_shift;
  logic       req0_dir;
  logic       req0_ready;

  logic       req1_valid;
  logic [3:0] req1_a;
  logic [1:0] req1_shift;
  logic       req1_dir;
  logic       req1_ready;

  logic       res_valid;
  logic [3:0] res_data;
  logic       res_id;
  logic       res_ready;

  modport master (
    output req0_valid, req0_a,
    output req0_shift, req0_dir,
    input  req0_ready,
    output req1_valid, req1_a,
    output req1_shift, req1_dir,
    input  req1_ready,
    input  res_valid, res_data, res_id,
    output res_ready
  );

  modport slave (
    input  req0_valid, req0_a,
    input  req0_shift, req0_dir,
    output req0_ready,
    input  req1_valid, req1_a,
    input  req1_shift, req1_dir,
    output req1_ready,
    output res_valid, res_data, res_id,
    input  res_ready
  );
endinterface

// File: rtl/shift_arbiter.sv
// Two-requester arbiter sharing one 4-bit logical shifter.
// SHIFT_ARB_ROUND_ROBIN_EN selects round-robin over fixed priority.
module shift_arbiter (
  input  logic           clk,
  input  logic           rst_n,
  shift_arbiter_if.slave bus
);

  typedef enum logic {
    EMPTY,
    FULL
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic       pref;
  logic       grant0;
  logic       grant1;
  logic       slot_free;
  logic       xfer;
  logic [3:0] sel_a;
  logic [1:0] sel_sh;
  logic       sel_dir;
  logic [3:0] shifted;
  logic [3:0] data_q;
  logic       id_q;

`ifdef SHIFT_ARB_ROUND_ROBIN_EN
  logic ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else if (xfer) begin
      ptr_q <= ~ptr_q;
    end
  end

  assign pref = ptr_q;
`else
  assign pref = 1'b0;
`endif

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    unique case ({bus.req1_valid, bus.req0_valid})
      2'b11: begin
        grant0 = ~pref;
        grant1 = pref;
      end
      2'b01: grant0 = 1'b1;
      2'b10: grant1 = 1'b1;
      default: ;
    endcase
  end

  // Draining a full slot frees it in the same cycle.
  assign slot_free = (state_q == EMPTY)
                   | bus.res_ready;

  assign bus.req0_ready = grant0 & slot_free;
  assign bus.req1_ready = grant1 & slot_free;
  assign xfer = bus.req0_ready | bus.req1_ready;

  always_comb begin
    sel_a   = bus.req0_a;
    sel_sh  = bus.req0_shift;
    sel_dir = bus.req0_dir;
    if (grant1) begin
      sel_a   = bus.req1_a;
      sel_sh  = bus.req1_shift;
      sel_dir = bus.req1_dir;
    end
  end

  always_comb begin
    shifted = sel_a << sel_sh;
    if (sel_dir) begin
      shifted = sel_a >> sel_sh;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: begin
        if (xfer) state_d = FULL;
      end
      FULL: begin
        if (xfer) begin
          state_d = FULL;
        end else if (bus.res_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= 4'b0000;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (xfer) begin
        data_q <= shifted;
        id_q   <= grant1;
      end
    end
  end

  assign bus.res_valid = (state_q == FULL);
  assign bus.res_data  = data_q;
  assign bus.res_id    = id_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter.
// Checks arbitration, shifts, backpressure, reset.
module tb_shift_arbiter;

  logic clk;
  logic rst_n;
  int   n_run;
  int   n_fail;

  shift_arbiter_if bus ();

  shift_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string      tag,
    input logic [3:0] obs,
    input logic [3:0] exp
  );
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(
    input logic       v,
    input logic [3:0] a,
    input logic [1:0] sh,
    input logic       dir
  );
    bus.req0_valid = v;
    bus.req0_a     = a;
    bus.req0_shift = sh;
    bus.req0_dir   = dir;
  endtask

  task automatic set1(
    input logic       v,
    input logic [3:0] a,
    input logic [1:0] sh,
    input logic       dir
  );
    bus.req1_valid = v;
    bus.req1_a     = a;
    bus.req1_shift = sh;
    bus.req1_dir   = dir;
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic exp_r1;
    logic exp_id;
    n_run  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    set0(1'b0, 4'b0000, 2'd0, 1'b0);
    set1(1'b0, 4'b0000, 2'd0, 1'b0);
    bus.res_ready = 1'b0;

    #3;
    chk("rst_valid", {3'b0, bus.res_valid}, 4'd0);
    chk("rst_data", bus.res_data, 4'b0000);
    chk("rst_id", {3'b0, bus.res_id}, 4'd0);
    chk("rst_rdy0", {3'b0, bus.req0_ready}, 4'd0);
    #9;
    rst_n = 1'b1;
    tick();

    // Both requesters valid for four cycles
    set0(1'b1, 4'b0001, 2'd0, 1'b0);
    set1(1'b1, 4'b0010, 2'd0, 1'b0);
    bus.res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
`ifdef SHIFT_ARB_ROUND_ROBIN_EN
      exp_r1 = (i % 2 == 1);
`else
      exp_r1 = 1'b0;
`endif
      #1;
      chk("arb_rdy1", {3'b0, bus.req1_ready},
          {3'b0, exp_r1});
      chk("arb_rdy0", {3'b0, bus.req0_ready},
          {3'b0, ~exp_r1});
      exp_id = exp_r1;
      tick();
      chk("arb_id", {3'b0, bus.res_id},
          {3'b0, exp_id});
      chk("arb_data", bus.res_data,
          exp_id ? 4'b0010 : 4'b0001);
    end
    set0(1'b0, 4'b0000, 2'd0, 1'b0);
    set1(1'b0, 4'b0000, 2'd0, 1'b0);
    tick();
    chk("drain_valid", {3'b0, bus.res_valid}, 4'd0);

    // Single requests
    set0(1'b1, 4'b0010, 2'd0, 1'b0);
    #1;
    chk("s0_rdy0", {3'b0, bus.req0_ready}, 4'd1);
    chk("s0_rdy1", {3'b0, bus.req1_ready}, 4'd0);
    tick();
    chk("s0_valid", {3'b0, bus.res_valid}, 4'd1);
    chk("s0_data", bus.res_data, 4'b0010);
    chk("s0_id", {3'b0, bus.res_id}, 4'd0);

    set0(1'b0, 4'b0000, 2'd0, 1'b0);
    set1(1'b1, 4'b1000, 2'd1, 1'b1);
    #1;
    chk("s1_rdy1", {3'b0, bus.req1_ready}, 4'd1);
    tick();
    chk("s1_data", bus.res_data, 4'b0100);
    chk("s1_id", {3'b0, bus.res_id}, 4'd1);
    set1(1'b0, 4'b0000, 2'd0, 1'b0);

    // Boundary shifts
    set0(1'b1, 4'b1111, 2'd2, 1'b0);
    tick();
    chk("b_l2", bus.res_data, 4'b1100);
    set0(1'b1, 4'b1001, 2'd3, 1'b1);
    tick();
    chk("b_r3", bus.res_data, 4'b0001);
    set0(1'b1, 4'b1001, 2'd3, 1'b0);
    tick();
    chk("b_l3", bus.res_data, 4'b1000);
    chk("b_id", {3'b0, bus.res_id}, 4'd0);
    set0(1'b0, 4'b0000, 2'd0, 1'b0);
    tick();
    chk("idle_valid", {3'b0, bus.res_valid}, 4'd0);
    chk("idle_hold", bus.res_data, 4'b1000);

    // Backpressure
    bus.res_ready = 1'b0;
    set0(1'b1, 4'b0011, 2'd1, 1'b0);
    #1;
    chk("bp_rdy_empty", {3'b0, bus.req0_ready}, 4'd1);
    tick();
    chk("bp_load", bus.res_data, 4'b0110);
    set0(1'b1, 4'b0101, 2'd1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("bp_rdy0", {3'b0, bus.req0_ready}, 4'd0);
      chk("bp_rdy1", {3'b0, bus.req1_ready}, 4'd0);
      tick();
      chk("bp_valid", {3'b0, bus.res_valid}, 4'd1);
      chk("bp_data", bus.res_data, 4'b0110);
      chk("bp_id", {3'b0, bus.res_id}, 4'd0);
    end
    bus.res_ready = 1'b1;
    #1;
    chk("bp_release", {3'b0, bus.req0_ready}, 4'd1);
    tick();
    chk("bb_valid", {3'b0, bus.res_valid}, 4'd1);
    chk("bb_data", bus.res_data, 4'b0010);

    // Reset while FULL
    set0(1'b0, 4'b0000, 2'd0, 1'b0);
    bus.res_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_valid", {3'b0, bus.res_valid}, 4'd0);
    chk("mr_data", bus.res_data, 4'b0000);
    chk("mr_id", {3'b0, bus.res_id}, 4'd0);
    #2;
    rst_n = 1'b1;
    set1(1'b1, 4'b0010, 2'd1, 1'b0);
    bus.res_ready = 1'b1;
    tick();
    chk("pr_valid", {3'b0, bus.res_valid}, 4'd1);
    chk("pr_data", bus.res_data, 4'b0100);
    chk("pr_id", {3'b0, bus.res_id}, 4'd1);
    set1(1'b0, 4'b0000, 2'd0, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 Parameters: none; data width is fixed at 4 bits and shift amount at 2 bits.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_a  input  4  requester 0 operand.
REQ-006 req0_shift  input  2  requester 0 shift amount, 0..3.
REQ-007 req0_dir  input  1  requester 0 direction: 0 = left, 1 = right.
REQ-008 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-009 req1_valid, req1_a, req1_shift, req1_dir, req1_ready: same widths and meanings for requester 1.
REQ-010 res_valid  output  1  result register holds a valid result.
REQ-011 res_data  output  4  shifted result.
REQ-012 res_id  output  1  index of the requester that produced res_data.
REQ-013 res_ready  input  1  consumer accepts the result this cycle.

Function
REQ-014 The block shall share one 4-bit logical shifter between two requesters through a valid/ready handshake on each side.
REQ-015 Transfer on a request port occurs when reqN_valid and reqN_ready are both 1 at a rising clk edge.
REQ-016 The output slot shall be a two-state FSM: EMPTY (res_valid=0) and FULL (res_valid=1).
REQ-017 slot_free = EMPTY, or FULL with res_ready=1 in the same cycle (back-to-back throughput of one operation per cycle).
REQ-018 At most one reqN_ready shall be 1 in any cycle; reqN_ready = grantN AND slot_free, combinational from current inputs and state.
REQ-019 Grant goes to the only valid requester; when both are valid, arbitration follows REQ-029/REQ-030.
REQ-020 On a transfer: res_data <= a << shift (left, zero-fill) or a >> shift (right, zero-fill), res_id <= N, res_valid <= 1; latency exactly one cycle.
REQ-021 shift = 0 shall pass a unchanged; bits shifted beyond bit 3 or below bit 0 are discarded.
REQ-022 FULL with res_ready=1 and no new transfer: next state EMPTY, res_valid <= 0.
REQ-023 FULL with res_ready=0: res_valid, res_data and res_id shall hold stable; both reqN_ready = 0.
REQ-024 EMPTY with no valid requester: remains EMPTY; outputs hold their last values.
REQ-025 Requesters shall hold operands stable while reqN_valid=1 and reqN_ready=0; the block does not latch unaccepted requests.

Reset
REQ-026 rst_n low shall immediately force res_valid=0, res_data=4'b0000, res_id=0, FSM to EMPTY and the priority pointer to requester 0, independent of clk.
REQ-027 Reset during FULL shall discard the pending result without completing its handshake.
REQ-028 On the first rising clk edge after rst_n deasserts, the block shall accept requests normally.

Configuration
REQ-029 Macro SHIFT_ARB_ROUND_ROBIN_EN defined: a 1-bit pointer names the preferred requester; on a simultaneous request it wins, and after every transfer the pointer moves to the other requester.
REQ-030 Macro not defined: fixed priority, requester 0 always wins a simultaneous request; the pointer register is not implemented.

Verification
REQ-031 Single requests, res_ready=1: req0 a=0010 shift=00 left -> next cycle res_data=0010, res_id=0; req1 a=1000 shift=01 right -> res_data=0100, res_id=1.
REQ-032 Boundary shifts: a=1111 shift=10 left -> 1100; a=1001 shift=11 right -> 0001; a=1001 shift=11 left -> 1000.
REQ-033 Both valid for 4 cycles, res_ready=1: with SHIFT_ARB_ROUND_ROBIN_EN, res_id sequence = 0,1,0,1; without it, res_id sequence = 0,0,0,0 and req1_ready stays 0.
REQ-034 Backpressure: result FULL with res_ready=0 for 3 cycles -> res_data and res_id stable, both reqN_ready=0; res_ready=1 with req0 valid -> new result loaded in the same edge (no bubble).
REQ-035 Reset mid-operation: rst_n low while FULL -> res_valid=0 and res_data=0000 before the next clk edge; after release, req1 a=0010 shift=01 left -> res_data=0100.
